pa_mem_port_arbiter: RTL and testbench
======================================

Name: pa_mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store) of the PA_RISC pipeline.
- Each access is a fixed-latency, multi-cycle transaction sequenced by an FSM.
- Produces per-requester done pulses, registered read data and combinational stall signals that freeze the owning pipeline stage.
- MEM stage has priority, with a bounded anti-starvation rule for fetch.

Parameters:
- ADDR_W, 9, byte address width of the memory port.
- DATA_W, 32, data width.
- MEM_LAT, 2, edges from the mem_en edge to the rdata capture edge (>=1).
- STARVE_MAX, 3, consecutive data grants allowed while fetch waits (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch address (PC front).
- if_done  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  DATA_W  fetched instruction, registered.
- if_stall  out  1  if_req & ~if_done.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load data, registered.
- d_stall  out  1  d_req & ~d_done.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write enable, valid with mem_en.
- mem_size  out  2  latched d_size; 10 for fetch.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (reset=0, any time, including mid-transaction):
  - state=IDLE, starve counter=0.
  - All outputs 0: mem_en, mem_we, mem_size, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata.
  - An in-flight transaction is abandoned; no done pulse follows.
- IDLE, arbitration at edge k:
  - d_req only -> data wins.
  - if_req only -> fetch wins.
  - Both -> data wins unless starve counter == STARVE_MAX, then fetch wins.
  - On a win: owner, address, we, size and wdata are latched; mem_en=1 for the cycle after edge k; state -> ACCESS.
  - Fetch grant forces mem_we=0 and mem_size=10.
- Starve counter:
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant, or on a data grant while if_req=0.
  - Saturates at STARVE_MAX.
- ACCESS:
  - Down-counter runs from MEM_LAT.
  - At edge k+MEM_LAT: the owner's rdata register captures mem_rdata (loads and fetches only; unchanged on stores).
  - Owner's done goes high for exactly the cycle after edge k+MEM_LAT; state -> DONE.
- DONE:
  - No arbitration in this cycle, even if requests are high.
  - Next edge returns to IDLE; arbitration resumes at edge k+MEM_LAT+1.
  - Throughput: one access per MEM_LAT+1 cycles.
- Flush, owner req dropped before done:
  - The transaction still runs to completion; a store issued on mem_en is performed.
  - The done pulse is suppressed if the owner's req=0 in the done cycle.
  - rdata is still captured.
- Outputs:
  - if_stall and d_stall are combinational.
  - mem_addr, mem_size, mem_we and mem_wdata hold their latched values until the next grant.
  - rdata registers hold until the next capture.
- The two done signals are never high in the same cycle.

Test Plan:
- Reset, then if_req=1, if_addr=0x010, MEM_LAT=2, mem_rdata=0xE8000010 -> mem_en high 1 cycle with mem_addr=0x010, mem_we=0, mem_size=10; if_done pulses 2 cycles later; if_rdata=0xE8000010; if_stall high until then.
- d_req and if_req both high, d_we=1, d_addr=0x044, d_wdata=0x12345678, d_size=10 -> store granted first (mem_we=1); fetch granted at the next arbitration edge (MEM_LAT+1 cycles later); if_stall high throughout.
- d_req held high continuously with if_req=1, STARVE_MAX=3 -> grant order is D,D,D,F,D,D,D,F; no fetch wait exceeds 3 data transactions.
- Drop if_req during ACCESS -> mem_en still issued, no if_done; next request granted at the normal edge; rdata register updated.
- Assert reset=0 during ACCESS of a load -> all outputs 0 immediately, no d_done after release; a re-asserted d_req is granted at the first edge after release.
- MEM_LAT=1, back-to-back fetches at 0x000, 0x004 -> a grant every 2 cycles; the DONE cycle never arbitrates; if_rdata matches each word.

Source files
------------

// File: rtl/pa_mem_port_arbiter.sv
// pa_mem_port_arbiter: shares one memory port between fetch and load/store, data first with bounded fetch starvation.
module pa_mem_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [SW-1:0]  starve;
    logic           owner_f, arb, grant_d, grant_f, last;

    // The edge leaving DONE arbitrates, so back-to-back accesses take MEM_LAT+1 cycles.
    assign arb     = state != ACCESS;
    assign grant_d = arb & d_req & (~if_req | (starve != SW'(STARVE_MAX)));
    assign grant_f = arb & if_req & ~grant_d;
    assign last    = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb
        state_nx = state == ACCESS ? (last ? DONE : ACCESS) : ((grant_d | grant_f) ? ACCESS : IDLE);

    // A requester that dropped its req (flush) gets no done pulse.
    always_comb begin
        if_done = (state == DONE) & owner_f & if_req;
        d_done  = (state == DONE) & ~owner_f & d_req;
    end

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt       <= '0;
            starve    <= '0;
            owner_f   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            mem_en <= grant_d | grant_f;
            cnt    <= state == ACCESS ? cnt - 1'b1 : CW'(MEM_LAT - 1);
            if (grant_d) begin
                owner_f   <= 1'b0;
                mem_addr  <= d_addr;
                mem_we    <= d_we;
                mem_size  <= d_size;
                mem_wdata <= d_wdata;
                starve    <= if_req ? (starve == SW'(STARVE_MAX) ? starve : starve + 1'b1) : '0;
            end else if (grant_f) begin
                owner_f  <= 1'b1;
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
                mem_size <= 2'b10;
                starve   <= '0;
            end
            if (last && owner_f)            if_rdata <= mem_rdata;
            if (last && !owner_f && !mem_we) d_rdata <= mem_rdata;
        end
endmodule

// File: tb/tb_pa_mem_port_arbiter.sv
// tb_pa_mem_port_arbiter: directed requests with a grant/done scoreboard for MEM_LAT=2 and MEM_LAT=1 instances.
module tb_pa_mem_port_arbiter;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    logic        if_req, d_req, d_we;
    logic [8:0]  if_addr, d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic        if_done, if_stall, d_done, d_stall, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic [8:0]  mem_addr;

    logic        if_req1, if_done1, if_stall1, d_done1, d_stall1, mem_en1, mem_we1;
    logic [8:0]  if_addr1, mem_addr1;
    logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
    logic [1:0]  mem_size1;

    pa_mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3)) u0 (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .if_rdata(if_rdata), .if_stall(if_stall), .d_req(d_req), .d_we(d_we), .d_size(d_size),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    pa_mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) u1 (
        .clk(clk), .reset(reset), .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1),
        .if_rdata(if_rdata1), .if_stall(if_stall1), .d_req(1'b0), .d_we(1'b0), .d_size(2'b00),
        .d_addr(9'h000), .d_wdata(32'h0), .d_done(d_done1), .d_rdata(d_rdata1), .d_stall(d_stall1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_size(mem_size1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

    // Memory contents: word at 0x010 is a branch instruction, others are 0xA0000000|addr, plus one stored word.
    function automatic logic [31:0] base(input logic [8:0] a);
        return (a[8:2] == 7'd4) ? 32'hE800_0010 : (32'hA000_0000 | 32'({a[8:2], 2'b00}));
    endfunction

    logic        st_vld = 1'b0;
    logic [6:0]  st_idx = '0;
    logic [31:0] st_val = '0;
    always @(posedge clk)
        if (reset && mem_en && mem_we) begin
            st_vld <= 1'b1;
            st_idx <= mem_addr[8:2];
            st_val <= mem_wdata;
        end
    assign mem_rdata  = (st_vld && mem_addr[8:2] == st_idx) ? st_val : base(mem_addr);
    assign mem_rdata1 = base(mem_addr1);

    int vectors = 0, miscompares = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct { logic [8:0] a; logic we; logic [1:0] sz; int gap; } grant_t;
    typedef struct { logic f; logic [31:0] rd; } done_t;
    grant_t gq[$], gq1[$];
    done_t  dq[$], dq1[$];
    int cyc = 0, last_en = 0, last_en1 = 0;
    always @(posedge clk) cyc++;

    task automatic push_g(input logic [8:0] a, input logic we, input logic [1:0] sz, input int gap);
        grant_t g;
        g.a = a; g.we = we; g.sz = sz; g.gap = gap;
        gq.push_back(g);
    endtask

    task automatic push_d(input logic f, input logic [31:0] rd);
        done_t d;
        d.f = f; d.rd = rd;
        dq.push_back(d);
    endtask

    always @(negedge clk) if (reset) begin
        grant_t g;
        done_t  d;
        if (if_done && d_done) chk("dual_done", 32'(if_done & d_done), 0);
        if (mem_en) begin
            chk("grant_expected", 32'(gq.size() != 0), 1);
            if (gq.size() != 0) begin
                g = gq.pop_front();
                chk("mem_addr", 32'(mem_addr), 32'(g.a));
                chk("mem_we", 32'(mem_we), 32'(g.we));
                chk("mem_size", 32'(mem_size), 32'(g.sz));
                if (g.gap != 0) chk("grant_gap", 32'(cyc - last_en), 32'(g.gap));
            end
            last_en = cyc;
        end
        if (if_done || d_done) begin
            chk("done_expected", 32'(dq.size() != 0), 1);
            chk("done_latency", 32'(cyc - last_en), 2);
            if (dq.size() != 0) begin
                d = dq.pop_front();
                chk("done_owner", 32'(if_done), 32'(d.f));
                chk("rdata", d.f ? if_rdata : d_rdata, d.rd);
            end
        end
    end

    always @(negedge clk) if (reset) begin
        grant_t g;
        done_t  d;
        if (mem_en1) begin
            chk("l1_grant_expected", 32'(gq1.size() != 0), 1);
            if (gq1.size() != 0) begin
                g = gq1.pop_front();
                chk("l1_mem_addr", 32'(mem_addr1), 32'(g.a));
                chk("l1_mem_size", 32'(mem_size1), 32'(g.sz));
                if (g.gap != 0) chk("l1_grant_gap", 32'(cyc - last_en1), 32'(g.gap));
            end
            last_en1 = cyc;
        end
        if (if_done1) begin
            chk("l1_done_expected", 32'(dq1.size() != 0), 1);
            chk("l1_done_latency", 32'(cyc - last_en1), 1);
            if (dq1.size() != 0) begin
                d = dq1.pop_front();
                chk("l1_if_rdata", if_rdata1, d.rd);
            end
        end
    end

    task automatic fetch(input logic [8:0] a, input logic drop);
        int n;
        n = 0;
        if_req = 1'b1; if_addr = a;
        do begin
            @(negedge clk); n++;
            if (!if_done) chk("if_stall", 32'(if_stall), 1);
        end while (!if_done && n < 40);
        chk("if_done_seen", 32'(if_done), 1);
        #1 if (drop) if_req = 1'b0;
    endtask

    task automatic dacc(input logic we, input logic [1:0] sz, input logic [8:0] a,
                        input logic [31:0] wd, input logic drop);
        int n;
        n = 0;
        d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        do begin
            @(negedge clk); n++;
            if (!d_done) chk("d_stall", 32'(d_stall), 1);
        end while (!d_done && n < 40);
        chk("d_done_seen", 32'(d_done), 1);
        #1 if (drop) d_req = 1'b0;
    endtask

    task automatic wait_en();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_en && n < 20);
        chk("mem_en_seen", 32'(mem_en), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_size"}, 32'(mem_size), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_done"}, 32'(if_done), 0);
        chk({tag, "_d_done"}, 32'(d_done), 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        grant_t g;
        done_t  d;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        if_req1 = 0; if_addr1 = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        #1 reset = 1'b1;
        @(negedge clk); #1;

        // Single fetch.
        push_g(9'h010, 0, 2'b10, 0); push_d(1, 32'hE800_0010);
        fetch(9'h010, 1);

        // Store and fetch together: store first, fetch at the next arbitration edge.
        push_g(9'h044, 1, 2'b10, 0); push_g(9'h020, 0, 2'b10, 3);
        push_d(0, 32'h0); push_d(1, 32'hA000_0020);
        fork
            fetch(9'h020, 1);
            dacc(1, 2'b10, 9'h044, 32'h1234_5678, 1);
        join

        // Continuous data traffic against a waiting fetch: D,D,D,F,D,D,D,F.
        push_g(9'h044, 0, 2'b10, 0); push_d(0, 32'h1234_5678);
        push_g(9'h048, 0, 2'b10, 3); push_d(0, 32'hA000_0048);
        push_g(9'h04C, 0, 2'b10, 3); push_d(0, 32'hA000_004C);
        push_g(9'h030, 0, 2'b10, 3); push_d(1, 32'hA000_0030);
        push_g(9'h050, 0, 2'b10, 3); push_d(0, 32'hA000_0050);
        push_g(9'h054, 0, 2'b10, 3); push_d(0, 32'hA000_0054);
        push_g(9'h058, 0, 2'b10, 3); push_d(0, 32'hA000_0058);
        push_g(9'h034, 0, 2'b10, 3); push_d(1, 32'hA000_0034);
        fork
            begin
                dacc(0, 2'b10, 9'h044, 0, 0); dacc(0, 2'b10, 9'h048, 0, 0);
                dacc(0, 2'b10, 9'h04C, 0, 0); dacc(0, 2'b10, 9'h050, 0, 0);
                dacc(0, 2'b10, 9'h054, 0, 0); dacc(0, 2'b10, 9'h058, 0, 1);
            end
            begin
                fetch(9'h030, 0); fetch(9'h034, 1);
            end
        join

        // Fetch flushed during ACCESS: no if_done, rdata still captured, load follows on time.
        push_g(9'h060, 0, 2'b10, 0);
        push_g(9'h064, 0, 2'b01, 3); push_d(0, 32'hA000_0064);
        if_req = 1'b1; if_addr = 9'h060;
        wait_en();
        #1 if_req = 1'b0;
        dacc(0, 2'b01, 9'h064, 0, 1);
        chk("flushed_if_rdata", if_rdata, 32'hA000_0060);

        // Reset in the middle of a load.
        push_g(9'h068, 0, 2'b10, 0);
        d_req = 1'b1; d_we = 0; d_size = 2'b10; d_addr = 9'h068;
        wait_en();
        #1 reset = 1'b0; d_addr = 9'h06C;
        #1 chk_zero("midreset");
        repeat (2) @(negedge clk);
        chk("reset_hold_mem_en", 32'(mem_en), 0);
        #1 reset = 1'b1;
        push_g(9'h06C, 0, 2'b10, 0); push_d(0, 32'hA000_006C);
        @(negedge clk);
        chk("grant_after_reset", 32'(mem_en), 1);
        #1 dacc(0, 2'b10, 9'h06C, 0, 1);

        // MEM_LAT=1 instance: back-to-back fetches every 2 cycles.
        g.a = 9'h000; g.we = 0; g.sz = 2'b10; g.gap = 0; gq1.push_back(g);
        g.a = 9'h004; g.gap = 2; gq1.push_back(g);
        d.f = 1; d.rd = 32'hA000_0000; dq1.push_back(d);
        d.rd = 32'hA000_0004; dq1.push_back(d);
        if_req1 = 1'b1; if_addr1 = 9'h000;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!if_done1 && n < 20);
            chk("l1_done_seen", 32'(if_done1), 1);
            #1 if_addr1 = 9'h004;
        end
        if_req1 = 1'b0;

        repeat (5) @(negedge clk);
        chk("grant_queue_drained", 32'(gq.size()), 0);
        chk("done_queue_drained", 32'(dq.size()), 0);
        chk("l1_grant_queue_drained", 32'(gq1.size()), 0);
        chk("l1_done_queue_drained", 32'(dq1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
